sim_finish_sequencer: RTL and testbench

//  Synthesizable end-of-simulation controller for cosim benches.

---
 rtl/sim_finish_sequencer.sv | 122 ++++++++++++
 tb/tb_sim_finish_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sim_finish_sequencer.sv
// sim_finish_sequencer: end-of-simulation controller; define SIM_KPRINT_EN to add the RAM-dump trigger/terminator handshake
module sim_finish_sequencer #(
    parameter logic [7:0]  TRIGGER_CHAR   = 8'h72,
    parameter logic [7:0]  TERM_CHAR      = 8'h2E,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CW             = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] report,
    input  logic        done,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic [31:0] report_q,
    output logic        report_changed,
    output logic [15:0] tx_count,
    output logic        finish,
    output logic        timed_out,
    output logic [2:0]  state
);
    typedef enum logic [1:0] {IDLE = 2'd0, INJECT = 2'd1, WAIT_TERM = 2'd2, FINISH = 2'd3} state_t;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
`ifdef SIM_KPRINT_EN
    localparam state_t ON_DONE = INJECT;
`else
    localparam state_t ON_DONE = FINISH;
`endif
    state_t      state_q, state_d;
    logic [31:0] rep_q, rep_d;
    logic        chg_q, chg_d;
    logic [15:0] txc_q, txc_d;
    logic        done_l_q, done_l_d;
    logic        fin_q, fin_d;
`ifdef SIM_KPRINT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic          to_q, to_d;
    logic          exit_now;
`endif
    // report tracking, saturating log-byte count, sticky done latch; finish trails entry into FINISH by a cycle
    always_comb begin
        rep_d    = report;
        chg_d    = report != rep_q;
        txc_d    = (tx_valid && txc_q != 16'hFFFF) ? txc_q + 16'd1 : txc_q;
        done_l_d = done_l_q | done;
        fin_d    = state_q == FINISH;
    end
    // next state; the normal exit of a dump phase takes priority over the timeout
    always_comb begin
        state_d = state_q;
`ifdef SIM_KPRINT_EN
        cnt_d    = cnt_q + CW'(1);
        hit_d    = hit_q;
        to_d     = hit_q;
        exit_now = (state_q == INJECT) ? rx_ready : (tx_valid && tx_data == TERM_CHAR);
`endif
        case (state_q)
            IDLE: begin
                state_d = (done_l_q || done) ? ON_DONE : IDLE;
`ifdef SIM_KPRINT_EN
                cnt_d   = '0;
`endif
            end
`ifdef SIM_KPRINT_EN
            INJECT, WAIT_TERM: begin
                state_d = exit_now ? ((state_q == INJECT) ? WAIT_TERM : FINISH)
                                   : ((cnt_q == TMAX) ? FINISH : state_q);
                hit_d   = !exit_now && cnt_q == TMAX;
            end
`endif
            default: ;
        endcase
    end
    // state and status registers; anything sampled during reset is discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rep_q    <= '0;
            chg_q    <= 1'b0;
            txc_q    <= '0;
            done_l_q <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rep_q    <= rep_d;
            chg_q    <= chg_d;
            txc_q    <= txc_d;
            done_l_q <= done_l_d;
            fin_q    <= fin_d;
        end
    end
`ifdef SIM_KPRINT_EN
    // dump timeout counter and timeout flags
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hit_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hit_q <= hit_d;
            to_q  <= to_d;
        end
    end
    assign rx_valid  = state_q == INJECT;
    assign timed_out = to_q;
`else
    logic unused_ok;
    assign unused_ok = ^{rx_ready, tx_data, TERM_CHAR, TMAX};
    assign rx_valid  = 1'b0;
    assign timed_out = 1'b0;
`endif
    assign rx_data        = rx_valid ? TRIGGER_CHAR : 8'h00;
    assign report_q       = rep_q;
    assign report_changed = chg_q;
    assign tx_count       = txc_q;
    assign finish         = fin_q;
    assign state          = {1'b0, state_q};
endmodule

// File: tb/tb_sim_finish_sequencer.sv
// tb_sim_finish_sequencer: randomized and directed checks of sim_finish_sequencer against a behavioural model
module tb_sim_finish_sequencer;
    localparam int TO = 16;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset = 1'b1, done = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
    logic [31:0] report = '0;
    logic [7:0]  tx_data = '0;
    logic [7:0]  rx_data;
    logic        rx_valid, report_changed, finish, timed_out;
    logic [31:0] report_q;
    logic [15:0] tx_count;
    logic [2:0]  state;
    int errors = 0, checks = 0;

    sim_finish_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .report(report), .done(done),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .report_q(report_q), .report_changed(report_changed), .tx_count(tx_count),
        .finish(finish), .timed_out(timed_out), .state(state)
    );

    // model: done requested, cycles spent dumping (-1 = not started), trigger accepted, end reached
    logic [31:0] m_rep = '0;
    logic        m_chg = 0, m_req = 0, m_acc = 0, m_end = 0, m_hit = 0, m_fin_o = 0, m_to_o = 0;
    int          m_txc = 0, m_age = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic go, term;
        go   = m_req || done;
        term = tx_valid && tx_data == 8'h2E;
        if (reset) begin
            m_rep = '0; m_chg = 0; m_txc = 0; m_req = 0; m_acc = 0;
            m_end = 0; m_hit = 0; m_age = -1; m_fin_o = 0; m_to_o = 0;
        end else begin
            m_fin_o = m_end;
            m_to_o  = m_hit;
            m_chg   = report != m_rep;
            m_rep   = report;
            if (tx_valid && m_txc < 65535) m_txc++;
            if (!m_end) begin
`ifdef SIM_KPRINT_EN
                if (m_age < 0) begin
                    if (go) m_age = 0;
                end else begin
                    if (m_age == TO - 1 && !(m_acc ? term : rx_ready)) begin
                        m_end = 1; m_hit = 1;
                    end else if (m_acc) m_end = term;
                    else m_acc = rx_ready;
                    m_age++;
                end
`else
                m_end = go;
`endif
            end
            m_req = go;
        end
    endtask

    task automatic step();
        logic rv;
        logic [2:0] st;
        model_update();
        @(posedge clk);
        #1;
        rv = m_age >= 0 && !m_acc && !m_end;
        st = m_end ? 3'd3 : (m_age >= 0 ? (m_acc ? 3'd2 : 3'd1) : 3'd0);
        chk("report_q", report_q, m_rep);
        chk("report_changed", 32'(report_changed), 32'(m_chg));
        chk("tx_count", 32'(tx_count), 32'(m_txc));
        chk("rx_valid", 32'(rx_valid), 32'(rv));
        chk("rx_data", 32'(rx_data), rv ? 32'h72 : 32'h0);
        chk("state", 32'(state), 32'(st));
        chk("finish", 32'(finish), 32'(m_fin_o));
        chk("timed_out", 32'(timed_out), 32'(m_to_o));
    endtask

    task automatic do_reset();
        reset = 1; done = 0; rx_ready = 0; tx_valid = 0; tx_data = '0;
        step();
        reset = 0;
    endtask

    task automatic send(input logic [7:0] b);
        tx_valid = 1; tx_data = b;
        step();
        tx_valid = 0;
    endtask

    initial begin
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_finish", 32'(finish), 0);
        chk("rst_tx_count", 32'(tx_count), 0);
        // done sampled during reset is dropped
        reset = 1; done = 1; step();
        reset = 0; done = 0; step();
        chk("done_in_reset", 32'(state), 0);
        // T1
        do_reset();
        repeat (4) step();
        report = 32'hDEADBEEF; step();
        chk("t1_report_q", report_q, 32'hDEADBEEF);
        chk("t1_changed", 32'(report_changed), 1);
        step();
        chk("t1_changed_drop", 32'(report_changed), 0);
`ifdef SIM_KPRINT_EN
        // T2
        do_reset();
        rx_ready = 1; done = 1; step(); done = 0;
        chk("t2_inject", 32'(state), 1);
        chk("t2_rx_data", 32'(rx_data), 32'h72);
        step(); rx_ready = 0;
        chk("t2_wait", 32'(state), 2);
        chk("t2_rx_drop", 32'(rx_valid), 0);
        send("a"); send("b"); send(".");
        chk("t2_fin_state", 32'(state), 3);
        chk("t2_fin_lag", 32'(finish), 0);
        step();
        chk("t2_finish", 32'(finish), 1);
        chk("t2_timed_out", 32'(timed_out), 0);
        chk("t2_tx_count", 32'(tx_count), 3);
        // T3
        do_reset();
        done = 1; step(); done = 0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_rx_valid", 32'(rx_valid), 1);
            chk("t3_rx_data", 32'(rx_data), 32'h72);
            step();
        end
        rx_ready = 1; step();
        chk("t3_accept", 32'(state), 2);
        step();
        chk("t3_single", 32'(rx_valid), 0);
        // T4
        do_reset();
        rx_ready = 1; done = 1; step(); done = 0;
        repeat (15) step();
        chk("t4_no_early", 32'(state), 2);
        step();
        chk("t4_state", 32'(state), 3);
        step();
        chk("t4_finish", 32'(finish), 1);
        chk("t4_timed_out", 32'(timed_out), 1);
        // terminator on the timeout cycle wins
        do_reset();
        rx_ready = 1; done = 1; step(); done = 0;
        repeat (15) step();
        send("."); step();
        chk("tie_finish", 32'(finish), 1);
        chk("tie_timed_out", 32'(timed_out), 0);
        // handshake on the timeout cycle wins
        do_reset();
        done = 1; step(); done = 0;
        repeat (15) step();
        rx_ready = 1; step();
        chk("tie_accept", 32'(state), 2);
        // T5
        do_reset();
        rx_ready = 1; done = 1; step(); done = 0; step();
        reset = 1; step(); reset = 0;
        chk("t5_state", 32'(state), 0);
        chk("t5_rx_valid", 32'(rx_valid), 0);
        send("."); step();
        chk("t5_no_finish", 32'(state), 0);
        chk("t5_tx_count", 32'(tx_count), 1);
        done = 1; step(); done = 0;
        chk("t5_new_done", 32'(state), 1);
`else
        // T6
        do_reset();
        done = 1; step(); done = 0;
        chk("t6_state", 32'(state), 3);
        chk("t6_fin_lag", 32'(finish), 0);
        step();
        chk("t6_finish", 32'(finish), 1);
        chk("t6_rx_valid", 32'(rx_valid), 0);
`endif
        // randomized episodes
        for (int i = 0; i < 3000; i++) begin
            reset    = (i % 150 == 0) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) report = $urandom;
            done     = $urandom_range(0, 39) == 0;
            rx_ready = $urandom_range(0, 1) == 1;
            tx_valid = $urandom_range(0, 2) != 0;
            tx_data  = ($urandom_range(0, 9) == 0) ? 8'h2E : 8'($urandom);
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
